// File: rtl/data_mem_lsu.sv
// data_mem_lsu: load/store unit between the MEM stage and a word-addressed,
// single-port data memory (1-cycle registered read, no byte enables).
// Byte-addressed RV32I loads/stores become word accesses; sub-word loads are
// sign/zero extended, sub-word stores are done as read-modify-write.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   i_req_*  / o_req_ready   CPU request (valid/ready, we, funct3, byte addr, wdata)
//   o_resp_valid/rdata/err   one-cycle completion pulse with load data / error flag
//   o_mem_* / i_mem_rdata    data memory port (request, we, word addr, wdata, rdata)
//
// state       | meaning
// S_IDLE      | ready; memory port driven straight from the incoming request
// S_LOAD_RESP | read data arriving; extend and register it
// S_RMW_WRITE | old word arriving; write it back with the new lane merged in
// S_RESP      | one-cycle response pulse

module data_mem_lsu #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [2:0]            i_req_funct3,
    input  logic [31:0]           i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    output logic                  o_resp_valid,
    output logic [DATA_WIDTH-1:0] o_resp_rdata,
    output logic                  o_resp_err,
    output logic                  o_mem_request,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LOAD_RESP = 2'd1,
        S_RMW_WRITE = 2'd2,
        S_RESP      = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH+1:0] r_addr;
    logic [2:0]            r_funct3;
    logic [31:0]           r_wdata;
    logic [31:0]           r_rdata;
    logic                  r_err;

    logic                  w_req;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [31:0]           w_wdata;
    logic                  w_illegal;
    logic                  w_accept;

    // Upper address bits alias onto the memory and are deliberately dropped.
    logic w_unused_addr;
    assign w_unused_addr = ^i_req_addr[31:ADDR_WIDTH+2];

    function automatic logic f_illegal(input logic we, input logic [2:0] f3,
                                       input logic [1:0] lo);
        logic ill;
        case (f3)
            3'b000, 3'b100: ill = 1'b0;
            3'b001, 3'b101: ill = lo[0];
            3'b010:         ill = |lo;
            default:        ill = 1'b1;
        endcase
        // Unsigned variants only exist for loads.
        if (we && f3[2]) ill = 1'b1;
        return ill;
    endfunction

    // Halves are always aligned by the time we get here, so shifting by the
    // byte offset selects either lane.
    function automatic logic [31:0] f_extend(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {lo, 3'b000};
        case (f3)
            3'b000:  res = {{24{sh[7]}}, sh[7:0]};
            3'b100:  res = {24'h0, sh[7:0]};
            3'b001:  res = {{16{sh[15]}}, sh[15:0]};
            3'b101:  res = {16'h0, sh[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] f_merge(input logic [2:0] f3, input logic [1:0] lo,
                                            input logic [31:0] word, input logic [31:0] wd);
        logic [31:0] mask;
        mask = (f3[1:0] == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
        mask = mask << {lo, 3'b000};
        return (word & ~mask) | ((wd << {lo, 3'b000}) & mask);
    endfunction

    assign w_illegal = f_illegal(i_req_we, i_req_funct3, i_req_addr[1:0]);
    assign w_accept  = (r_state == S_IDLE) && i_req_valid;

    always_comb begin
        w_next      = r_state;
        o_req_ready = 1'b0;
        w_req       = 1'b0;
        w_we        = 1'b0;
        w_addr      = r_addr[ADDR_WIDTH+1:2];
        w_wdata     = r_wdata;
        case (r_state)
            S_IDLE: begin
                o_req_ready = 1'b1;
                w_addr      = i_req_addr[ADDR_WIDTH+1:2];
                w_wdata     = i_req_wdata;
                if (i_req_valid) begin
                    if (w_illegal) begin
                        w_next = S_RESP;
                    end else if (!i_req_we) begin
                        w_req  = 1'b1;
                        w_next = S_LOAD_RESP;
                    end else if (i_req_funct3 == 3'b010) begin
                        w_req  = 1'b1;
                        w_we   = 1'b1;
                        w_next = S_RESP;
                    end else begin
                        w_req  = 1'b1;
                        w_next = S_RMW_WRITE;
                    end
                end
            end
            S_LOAD_RESP: w_next = S_RESP;
            S_RMW_WRITE: begin
                w_req   = 1'b1;
                w_we    = 1'b1;
                w_wdata = f_merge(r_funct3, r_addr[1:0], i_mem_rdata, r_wdata);
                w_next  = S_RESP;
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_funct3 <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr   <= i_req_addr[ADDR_WIDTH+1:0];
                r_funct3 <= i_req_funct3;
                r_wdata  <= i_req_wdata;
                r_rdata  <= '0;
                r_err    <= w_illegal;
            end else if (r_state == S_LOAD_RESP) begin
                r_rdata <= f_extend(r_funct3, r_addr[1:0], i_mem_rdata);
            end
        end
    end

    // The memory write path ignores reset, so the port is gated here.
    assign o_mem_request = rst_n & w_req;
    assign o_mem_we      = rst_n & w_we;
    assign o_mem_addr    = w_addr;
    assign o_mem_wdata   = w_wdata;

    assign o_resp_valid = (r_state == S_RESP);
    assign o_resp_rdata = o_resp_valid ? r_rdata : '0;
    assign o_resp_err   = o_resp_valid & r_err;

endmodule

// File: doc/data_mem_lsu.md
Name: data_mem_lsu

Overview:
Load/store unit between the pipeline MEM stage and the word-addressed, single-port data memory (1-cycle registered read, write-only-when-requested, no byte enables). Converts byte-addressed RV32I loads/stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses. Performs sign/zero extension on loads and read-modify-write for sub-word stores. Flags misaligned or illegal accesses.

Parameters:
ADDR_WIDTH, 7, word-address width of the data memory (NUM_WORDS = 2**ADDR_WIDTH)
DATA_WIDTH, 32, data width; only 32 is supported

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  CPU request valid
req_ready  out  1  unit can accept a request; high only in IDLE
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
req_addr  in  32  byte address
req_wdata  in  32  store data; low bits hold the byte/half
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  misaligned/illegal access; qualified by resp_valid
mem_request  out  1  to memory request
mem_we  out  1  to memory we
mem_addr  out  ADDR_WIDTH  word address = req_addr[ADDR_WIDTH+1:2]
mem_wdata  out  32  to memory data_i
mem_rdata  in  32  from memory data_o; valid the cycle after a read request

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0, latched request cleared.
- mem_request is forced to 0 while rst_n=0. The memory's write path ignores reset, so this gating is mandatory.
- Address bits above ADDR_WIDTH+1 are ignored (aliasing).
- Accept occurs when req_valid && req_ready. On accept, latch addr, funct3, we, wdata.
- In IDLE, the memory signals are combinational from the incoming request, so the first memory access happens in the accept cycle. In all other states they come from latched values.
- Error check at accept:
  - H/HU with addr[0]=1: error.
  - W with addr[1:0]!=0: error.
  - funct3 in {011,110,111}: error.
  - Loads with funct3 100/101 are legal; stores with funct3 other than 000/001/010 are errors.
  - On error: mem_request=0; go to RESP.
- States:
  - IDLE: req_ready=1.
    - Legal load: mem_request=1, mem_we=0; go to LOAD_RESP.
    - SW: mem_request=1, mem_we=1, mem_wdata=req_wdata; go to RESP.
    - SB/SH: mem_request=1, mem_we=0 (read old word); go to RMW_WRITE.
  - LOAD_RESP: select the byte (addr[1:0]) or half (addr[1]) from mem_rdata, sign- or zero-extend it, and register resp_rdata. resp_valid=1 next cycle, i.e. go to RESP carrying the data. Latency: accept at cycle N, resp_valid at N+2.
  - RMW_WRITE: mem_request=1, mem_we=1. mem_wdata = mem_rdata with the target byte/half lane replaced by wdata[7:0] or wdata[15:0]; the other lanes are unchanged. Go to RESP.
  - RESP: resp_valid=1 for exactly one cycle with resp_rdata/resp_err; next state IDLE. req_ready=0. The next request can be accepted the cycle after RESP.
- Completion timing: SW and error responses complete at N+1; loads at N+2; SB/SH at N+2. Correct this: SW/error resp_valid at N+1, load resp_valid at N+2, SB/SH resp_valid at N+2, with the RMW write at N+1.
- mem_request=0 in RESP and whenever IDLE has no valid request.
- Requests presented while req_ready=0 are ignored; the CPU holds them.
- Reset mid-operation returns to IDLE with no memory write issued in that cycle and no response.

Test Plan:
- SW addr 0x10 data 0xAABBCCDD, then LW 0x10 -> mem[4]=0xAABBCCDD; LW resp_valid 2 cycles after accept, rdata 0xAABBCCDD, err 0.
- Preload mem[4]=0x8899AABB. LB 0x13 -> 0xFFFFFF88; LBU 0x13 -> 0x00000088; LH 0x10 -> 0xFFFFAABB; LHU 0x12 -> 0x00008899.
- mem[4]=0x11223344. SB 0x11 wdata 0xFF -> mem[4]=0x1122FF44. Then SH 0x12 wdata 0xBEEF -> mem[4]=0xBEEFFF44. Exactly one write per store, issued in RMW_WRITE.
- LW 0x12, SH 0x13, funct3=011 -> resp_err=1, rdata 0, resp_valid 1 cycle after accept, mem_request never asserted.
- Hold rst_n=0 with req_valid=1/req_we=1 -> mem_request stays 0, memory unchanged. Assert reset during RMW_WRITE -> no write, no resp_valid, req_ready=1 after release.
- Back-to-back req_valid held high -> req_ready low from the cycle after accept until after RESP; exactly one resp_valid per request.
